// File: rtl/fifo_access_sched.sv
// fifo_access_sched: grant scheduler and pointer/occupancy bookkeeping for the
// shared byte FIFO written by ports 1/2 and drained by port 3.
// One transfer is granted per IDLE->GRANT pass, so the peak rate is one transfer
// every two cycles. At most one grant is high in any cycle.
module fifo_access_sched #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int HI_WM = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             treq1,
    input  logic             treq2,
    input  logic             treq3,
    output logic             tgrant1,
    output logic             tgrant2,
    output logic             tgrant3,
    output logic             wr_en,
    output logic             wr_sel,
    output logic [PTR_W-1:0] wr_ptr,
    output logic             rd_en,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] HI_C    = (PTR_W+1)'(HI_WM);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_q, grant_d;  // one-hot, bit0=port1 .. bit2=port3
    logic [1:0]         last_q, last_d;    // last served port index, 0..2
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;

    logic [2:0]         elig;
    logic [1:0]         sel;
    logic [1:0]         idx;

    // Next-state: pick a requester in IDLE, retire the granted transfer in GRANT.
    always_comb begin
        state_d  = state_q;
        grant_d  = '0;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        full_d   = full_q;
        empty_d  = empty_q;
        sel      = '0;
        idx      = '0;
        // Writers are blocked when full, the reader when empty; this is what
        // keeps count inside 0..DEPTH.
        elig     = {treq3 && !empty_q, treq2 && !full_q, treq1 && !full_q};

        case (state_q)
            IDLE: begin
                if (|elig) begin
                    if (elig[2] && count_q >= HI_C) begin
                        sel = 2'd2;
                    end else begin
                        // Scan from farthest to nearest so the nearest eligible
                        // port after last_q is the one left in sel.
                        for (int k = 3; k >= 1; k--) begin
                            idx = 2'((int'(last_q) + k) % 3);
                            if (elig[idx]) sel = idx;
                        end
                    end
                    grant_d[sel] = 1'b1;
                    last_d       = sel;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                state_d = IDLE;
                if (grant_q[0] || grant_q[1]) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                end else if (grant_q[2]) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                end
                full_d  = (count_d == DEPTH_C);
                empty_d = (count_d == '0);
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset wins over any grant in progress.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= 2'd2;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign tgrant1 = grant_q[0];
    assign tgrant2 = grant_q[1];
    assign tgrant3 = grant_q[2];
    assign wr_en   = grant_q[0] | grant_q[1];
    assign wr_sel  = grant_q[1];
    assign rd_en   = grant_q[2];
    assign wr_ptr  = wr_ptr_q;
    assign rd_ptr  = rd_ptr_q;
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: tb/tb_fifo_access_sched.sv
// Testbench for fifo_access_sched: a cycle model predicts grants into a
// scoreboard queue; observed grants pop and compare against it.
module tb_fifo_access_sched;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       treq1 = 1'b0, treq2 = 1'b0, treq3 = 1'b0;
    logic       tgrant1, tgrant2, tgrant3;
    logic       wr_en, wr_sel, rd_en;
    logic [2:0] wr_ptr, rd_ptr;
    logic [3:0] count;
    logic       full, empty;

    int checks   = 0;
    int failures = 0;
    int obs_g    = 0;

    // Reference model state (state after the most recently stepped edge).
    int m_st = 0, m_g = 0, m_last = 3, m_wp = 0, m_rp = 0, m_cnt = 0;

    typedef struct {
        int port;
        int wp;
        int rp;
        int cnt;
    } exp_t;
    exp_t sbq[$];

    fifo_access_sched #(.DEPTH(8), .PTR_W(3), .HI_WM(6)) dut (
        .clock(clock), .reset(reset),
        .treq1(treq1), .treq2(treq2), .treq3(treq3),
        .tgrant1(tgrant1), .tgrant2(tgrant2), .tgrant3(tgrant3),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_ptr(wr_ptr),
        .rd_en(rd_en), .rd_ptr(rd_ptr),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clock = ~clock;

    function automatic bit eligible(input int p, input bit t1, t2, t3);
        case (p)
            1: return t1 && m_cnt < 8;
            2: return t2 && m_cnt < 8;
            default: return t3 && m_cnt > 0;
        endcase
    endfunction

    // Advance the model across one rising edge; predicted grants go to the queue.
    task automatic model_step(input bit t1, t2, t3, rst);
        int pick;
        int p;
        exp_t e;
        if (!rst) begin
            m_st = 0; m_g = 0; m_last = 3; m_wp = 0; m_rp = 0; m_cnt = 0;
        end else if (m_st == 1) begin
            if (m_g == 3) begin
                m_rp = (m_rp + 1) % 8; m_cnt = m_cnt - 1;
            end else begin
                m_wp = (m_wp + 1) % 8; m_cnt = m_cnt + 1;
            end
            m_g = 0; m_st = 0;
        end else begin
            pick = 0;
            if (eligible(3, t1, t2, t3) && m_cnt >= 6) pick = 3;
            else begin
                p = m_last;
                repeat (3) begin
                    p = p % 3 + 1;
                    if (pick == 0 && eligible(p, t1, t2, t3)) pick = p;
                end
            end
            if (pick != 0) begin
                e.port = pick; e.wp = m_wp; e.rp = m_rp; e.cnt = m_cnt;
                sbq.push_back(e);
                m_g = pick; m_last = pick; m_st = 1;
            end
        end
    endtask

    // One clock: drive inputs, step the model, then score the DUT after the edge.
    task automatic cyc(input bit t1, t2, t3, rst);
        exp_t e;
        int   dg;
        @(negedge clock);
        treq1 = t1; treq2 = t2; treq3 = t3; reset = rst;
        model_step(t1, t2, t3, rst);
        @(posedge clock);
        #1;
        dg = tgrant1 ? 1 : (tgrant2 ? 2 : (tgrant3 ? 3 : 0));
        obs_g = dg;
        checks++;
        if ($countones({tgrant1, tgrant2, tgrant3}) > 1) begin
            failures++;
            $display("FAIL onehot grants=%b required at most one", {tgrant3, tgrant2, tgrant1});
        end
        if (dg != 0) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got port %0d required no grant", dg);
            end else begin
                e = sbq.pop_front();
                if (dg != e.port || wr_ptr !== 3'(e.wp) || rd_ptr !== 3'(e.rp) ||
                    count !== 4'(e.cnt) || wr_en !== (e.port != 3) ||
                    wr_sel !== (e.port == 2) || rd_en !== (e.port == 3)) begin
                    failures++;
                    $display("FAIL sb_grant got port=%0d wp=%0d rp=%0d cnt=%0d we=%b ws=%b re=%b required port=%0d wp=%0d rp=%0d cnt=%0d",
                             dg, wr_ptr, rd_ptr, count, wr_en, wr_sel, rd_en,
                             e.port, e.wp, e.rp, e.cnt);
                end
            end
        end else if (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            failures++;
            $display("FAIL sb_missing got no grant required port %0d", e.port);
        end
        checks++;
        if (count !== 4'(m_cnt) || full !== (m_cnt == 8) || empty !== (m_cnt == 0) ||
            wr_ptr !== 3'(m_wp) || rd_ptr !== 3'(m_rp)) begin
            failures++;
            $display("FAIL state got cnt=%0d full=%b empty=%b wp=%0d rp=%0d required cnt=%0d wp=%0d rp=%0d",
                     count, full, empty, wr_ptr, rd_ptr, m_cnt, m_wp, m_rp);
        end
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    // Hold the given requests until a grant shows (bounded), return its port.
    task automatic wait_grant(input bit t1, t2, t3, output int port);
        port = 0;
        for (int i = 0; i < 6 && port == 0; i++) begin
            cyc(t1, t2, t3, 1);
            port = obs_g;
        end
        if (port == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout got no grant within 6 cycles required one");
        end
    endtask

    task automatic xfer(input bit t1, t2, t3);
        int p;
        wait_grant(t1, t2, t3, p);
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_reset();
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 0);
        checks++;
        if ({tgrant1, tgrant2, tgrant3, wr_en, rd_en, wr_sel} !== 6'b0 || count !== 4'd0 ||
            empty !== 1'b1 || full !== 1'b0 || wr_ptr !== 3'd0 || rd_ptr !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got g=%b cnt=%0d empty=%b full=%b wp=%0d rp=%0d required zeros, empty=1",
                     {tgrant3, tgrant2, tgrant1}, count, empty, full, wr_ptr, rd_ptr);
        end
        cyc(1, 1, 1, 1);
        checks++;
        if (tgrant1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant got tgrant1=%b required 1", tgrant1);
        end
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_fill();
        int n = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 1);
            if (obs_g == 1) begin
                checks++;
                if (wr_ptr !== 3'(n)) begin
                    failures++;
                    $display("FAIL fill_wr_ptr got %0d required %0d", wr_ptr, n);
                end
                n++;
            end
        end
        checks++;
        if (n != 8 || full !== 1'b1 || count !== 4'd8) begin
            failures++;
            $display("FAIL fill_full got grants=%0d full=%b cnt=%0d required 8,1,8", n, full, count);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 1);
            checks++;
            if (obs_g != 0) begin
                failures++;
                $display("FAIL fill_blocked got port %0d required none", obs_g);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[6] = '{1, 2, 3, 1, 2, 3};
        int k = 0;
        // Drain from full down to 2 with the reader alone.
        for (int i = 0; i < 30 && !(m_cnt == 2 && m_st == 0); i++) cyc(0, 0, 1, 1);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, 1, 1);
            if (obs_g != 0 && k < 6) begin
                checks++;
                if (obs_g != exp_seq[k] || wr_sel !== (exp_seq[k] == 2)) begin
                    failures++;
                    $display("FAIL rr_order idx %0d got port %0d wr_sel=%b required port %0d",
                             k, obs_g, wr_sel, exp_seq[k]);
                end
                k++;
            end
        end
        checks++;
        if (k != 6 || count !== 4'd4) begin
            failures++;
            $display("FAIL rr_count got grants=%0d cnt=%0d required 6,4", k, count);
        end
    endtask

    task automatic test_watermark();
        int p;
        do_reset();
        for (int i = 0; i < 7; i++) xfer(1, 0, 0);
        xfer(0, 0, 1);                 // count 6, last served = reader
        wait_grant(1, 0, 1, p);
        checks++;
        if (p != 3 || count !== 4'd6) begin
            failures++;
            $display("FAIL wm_reader_first got port %0d cnt=%0d required port 3 cnt 6", p, count);
        end
        cyc(1, 0, 1, 1);
        wait_grant(1, 0, 1, p);
        checks++;
        if (p != 1 || count !== 4'd5) begin
            failures++;
            $display("FAIL wm_below got port %0d cnt=%0d required port 1 cnt 5", p, count);
        end
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_empty_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 1);
            checks++;
            if (obs_g != 0) begin
                failures++;
                $display("FAIL empty_read got port %0d required none", obs_g);
            end
        end
        for (int i = 0; i < 10; i++) begin
            xfer(1, 0, 0);
            xfer(0, 0, 1);
        end
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || wr_ptr !== 3'd2 || rd_ptr !== 3'd2) begin
            failures++;
            $display("FAIL wrap_final got cnt=%0d empty=%b wp=%0d rp=%0d required 0,1,2,2",
                     count, empty, wr_ptr, rd_ptr);
        end
    endtask

    task automatic test_reset_mid();
        int p;
        do_reset();
        for (int i = 0; i < 5; i++) xfer(1, 0, 0);
        wait_grant(1, 0, 0, p);
        checks++;
        if (p != 1 || wr_ptr !== 3'd5) begin
            failures++;
            $display("FAIL mid_grant got port %0d wp=%0d required port 1 wp 5", p, wr_ptr);
        end
        cyc(1, 0, 0, 0);
        checks++;
        if (tgrant1 !== 1'b0 || wr_ptr !== 3'd0 || count !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset got tgrant1=%b wp=%0d cnt=%0d required 0,0,0", tgrant1, wr_ptr, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_round_robin();
        test_watermark();
        test_empty_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
